// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator with pixel strobe, h/v counters, sync
//               pulses, visible-area flag and frame-start strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int   CLK_DIV  = 4,
    parameter int   H_DISP   = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_DISP   = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       frame_start
);

    localparam int         c_h_total  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int         c_v_total  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam logic [3:0] c_div_max  = 4'(CLK_DIV - 1);
    localparam logic [9:0] c_h_max    = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_max    = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_disp   = 10'(H_DISP);
    localparam logic [9:0] c_v_disp   = 10'(V_DISP);
    localparam logic [9:0] c_hs_first = 10'(H_DISP + H_FP);
    localparam logic [9:0] c_hs_last  = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_vs_first = 10'(V_DISP + V_FP);
    localparam logic [9:0] c_vs_last  = 10'(V_DISP + V_FP + V_SYNC - 1);

    generate
        if (c_h_total > 1024 || c_v_total > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be in 1..16");
        end
    endgenerate

    logic [3:0] r_div;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_valid;
    logic       r_frame_start;

    logic       w_pix_tick;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;

    // Reset dominates the strobe so nothing advances while rst is held.
    assign w_pix_tick = ~rst & (r_div == c_div_max);
    assign w_h_wrap   = (r_h_cnt == c_h_max);
    assign w_v_wrap   = (r_v_cnt == c_v_max);

    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (w_pix_tick) begin
            if (w_h_wrap) begin
                w_h_next = '0;
                w_v_next = w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                w_h_next = r_h_cnt + 10'd1;
            end
        end
    end

    // Decoded outputs load from the next-counter values so they line up with
    // h_cnt/v_cnt in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_valid       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= (r_div == c_div_max) ? 4'd0 : r_div + 4'd1;
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_hsync       <= (w_h_next >= c_hs_first && w_h_next <= c_hs_last) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_v_next >= c_vs_first && w_v_next <= c_vs_last) ? SYNC_POL : ~SYNC_POL;
            r_valid       <= (w_h_next < c_h_disp) && (w_v_next < c_v_disp);
            r_frame_start <= w_pix_tick & w_h_wrap & w_v_wrap;
        end
    end

    assign pix_tick    = w_pix_tick;
    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign valid       = r_valid;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire
